instr_fetch: RTL

Instruction fetch unit: the producer side of the instruction word consumed by `controller`. It reads 8-bit program memory through a req/ack handshake and maintains the program counter. When the decoder flags `rimm`, it fetches the following immediate byte. It then presents the opcode/immediate pair to the core with a valid/ready handshake and applies taken jumps on acceptance. It sits between program memory and the decode/datapath stage.

---
 rtl/instr_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Reads opcode bytes, plus an optional immediate byte, from 8-bit program
// memory over a req/ack handshake. The opcode/immediate pair is offered to the
// core over a valid/ready handshake, and a taken jump is applied when the core
// accepts the instruction.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              rimm,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] br_target
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        IMM,
        ISSUE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_ptr;

    // The read address always follows the fetch pointer; it only matters while mem_req is high.
    assign mem_addr = fetch_ptr;

    // Fetch sequencer. mem_req and instr_valid are flops set for the state being entered,
    // so they always match the registered state and never depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_ptr   <= RESET_PC;
            pc          <= RESET_PC;
            instr       <= '0;
            imm         <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (mem_ack) begin
                        instr     <= mem_rdata;
                        pc        <= fetch_ptr;
                        fetch_ptr <= fetch_ptr + ADDR_W'(1);
                        mem_req   <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    // rimm is decoded from the instr register loaded on the previous edge
                    if (rimm) begin
                        mem_req <= 1'b1;
                        state   <= IMM;
                    end else begin
                        imm         <= '0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                IMM: begin
                    if (mem_ack) begin
                        imm         <= mem_rdata;
                        fetch_ptr   <= fetch_ptr + ADDR_W'(1);
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        // without a jump, fetch_ptr already points past this instruction
                        if (pc_src) begin
                            fetch_ptr <= br_target;
                        end
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
